pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the three-register siiCpu pipeline: PC, IF/ID register and the EX register (ID+ALU results latched for the MEM/WB stage).
- Generates per-register stall and flush controls from four sources:
  - load-use hazards
  - the data-memory request/acknowledge handshake of the instruction held in the EX register
  - taken branches
  - traps
- Owns the memory-wait state machine, the memory timeout watchdog and a stall-cycle performance counter.

Parameters:
- GPR_ADDR_W, 5, width of GPR register addresses.
- MEM_TIMEOUT, 255, cycles spent in MEM_WAIT without mem_ack before timeout_err fires; legal range 1..65535.
- CNT_W, 16, width of the stall_cnt performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_en  in  1  ID stage holds a valid instruction
- id_rs1_addr  in  GPR_ADDR_W  ID source register 1
- id_rs2_addr  in  GPR_ADDR_W  ID source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_en  in  1  EX register holds a valid instruction
- ex_dst_addr  in  GPR_ADDR_W  EX register destination
- ex_is_load  in  1  EX instruction is a load
- ex_is_mem  in  1  EX instruction accesses data memory (load or store)
- mem_ack  in  1  data bus completes the access this cycle
- br_taken  in  1  branch/jump resolved taken in ID
- trap_req  in  1  exception/interrupt accepted this cycle
- mem_req  out  1  data bus request
- pc_stall  out  1  hold PC
- if_stall  out  1  hold IF/ID register
- ex_stall  out  1  hold EX register
- if_flush  out  1  IF/ID register loads a bubble
- ex_flush  out  1  EX register loads a bubble (en=0, gpr_we_ inactive, mem_op=0)
- timeout_err  out  1  one-cycle pulse on memory timeout
- stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset: while reset=0, every output is 0 regardless of inputs; state=IDLE, timeout counter=0, stall_cnt=0. If reset asserts during MEM_WAIT, the access is abandoned: mem_req drops immediately and no ack is awaited after release.
- States: IDLE, MEM_WAIT, TRAP_FLUSH (2-bit encoding).
- Internal terms:
  - mem_active = ex_en & ex_is_mem & state!=TRAP_FLUSH
  - mem_stall = mem_active & !mem_ack
  - load_use = id_en & ex_en & ex_is_load & ex_dst_addr!=0 & ((id_rs1_used & id_rs1_addr==ex_dst_addr) | (id_rs2_used & id_rs2_addr==ex_dst_addr))
- mem_req = mem_active & !trap_req. Combinational: the request is raised in the same cycle the instruction appears in the EX register. A zero-wait ack (ack in the request cycle) causes no stall.
- Priority, highest first; outputs are combinational from state and inputs:
  1. trap_req=1 or state=TRAP_FLUSH: if_flush=1, ex_flush=1; all stalls 0; mem_req=0.
  2. mem_stall: pc_stall=if_stall=ex_stall=1; no flushes. A concurrent br_taken or load_use is deferred; the held inputs re-present it later.
  3. load_use: pc_stall=if_stall=1, ex_flush=1 (one bubble). Next cycle ex_en=0, so the hazard clears.
  4. br_taken: if_flush=1.
- Transitions:
  - IDLE -> MEM_WAIT: mem_stall & !trap_req.
  - MEM_WAIT -> IDLE: mem_ack.
  - MEM_WAIT -> IDLE: trap_req (access aborted).
  - MEM_WAIT -> TRAP_FLUSH: timeout counter reaches MEM_TIMEOUT-1 while mem_ack=0.
  - TRAP_FLUSH -> IDLE: unconditional, after 1 cycle.
- Timeout counter: cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle with mem_ack=0.
- timeout_err: registered; high exactly in the first TRAP_FLUSH cycle.
- mem_ack and timeout on the same cycle: the ack wins; no timeout.
- mem_ack outside mem_active: ignored.
- stall_cnt: increments on every clock edge where pc_stall=1; saturates at all-ones and does not wrap.

Test Plan:
- Load-use: EX holds a load with dst x5 and ex_en=1; ID reads rs2=x5, mem_ack=1 same cycle -> pc_stall=if_stall=1, ex_flush=1 for exactly 1 cycle; next cycle all 0; stall_cnt=1. Repeat with dst x0 -> no stall.
- Wait-state access: store in EX, mem_ack after 3 cycles -> mem_req high 4 cycles; pc/if/ex_stall high 3 cycles, low on the ack cycle; state back to IDLE; stall_cnt=3.
- Load waits 2 cycles while ID depends on it -> 2 cycles with ex_stall=1, then ack cycle gives ex_flush=1 with pc_stall=if_stall=1; total 3 stall cycles.
- Timeout with MEM_TIMEOUT=4, ack never arrives -> MEM_WAIT for 4 cycles, then TRAP_FLUSH for 1 cycle with timeout_err=1, if_flush=ex_flush=1, mem_req=0; then IDLE.
- Simultaneous trap_req, br_taken and load_use -> only if_flush=ex_flush=1, no stalls. Trap during MEM_WAIT -> mem_req drops the same cycle; IDLE next cycle.
- Async reset asserted mid MEM_WAIT -> outputs 0 immediately; after release, state IDLE and stall_cnt=0. Force stall_cnt to 16'hFFFE with a continuous stall -> holds at 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Pipeline sequencing controller for the PC / IF-ID / EX registers.
//             Combines load-use, data-memory wait, branch and trap sources
//             into per-register stall/flush controls. Owns the memory-wait
//             FSM, the memory timeout watchdog and a stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int GPR_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_en,
  input  logic [GPR_ADDR_W-1:0] id_rs1_addr,
  input  logic [GPR_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_en,
  input  logic [GPR_ADDR_W-1:0] ex_dst_addr,
  input  logic                  ex_is_load,
  input  logic                  ex_is_mem,
  input  logic                  mem_ack,
  input  logic                  br_taken,
  input  logic                  trap_req,
  output logic                  mem_req,
  output logic                  pc_stall,
  output logic                  if_stall,
  output logic                  ex_stall,
  output logic                  if_flush,
  output logic                  ex_flush,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [1:0]  c_IDLE       = 2'd0;
  localparam logic [1:0]  c_MEM_WAIT   = 2'd1;
  localparam logic [1:0]  c_TRAP_FLUSH = 2'd2;
  // Last MEM_WAIT count value before the watchdog fires.
  localparam logic [15:0] c_TMO_LAST   = 16'(MEM_TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [15:0]      tmo_cnt_q;
  logic             timeout_err_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic w_mem_active, w_mem_stall, w_mem_ack, w_load_use, w_tmo_hit;
  logic w_rs1_hit, w_rs2_hit;
  logic w_mem_req, w_pc_stall, w_if_stall, w_ex_stall, w_if_flush, w_ex_flush;

  // The access is suspended while the trap flush bubble passes through EX.
  assign w_mem_active = ex_en & ex_is_mem & (state_q != c_TRAP_FLUSH);
  assign w_mem_stall  = w_mem_active & ~mem_ack;
  // An ack with no access in flight carries no meaning.
  assign w_mem_ack    = w_mem_active & mem_ack;

  assign w_rs1_hit  = id_rs1_used & (id_rs1_addr == ex_dst_addr);
  assign w_rs2_hit  = id_rs2_used & (id_rs2_addr == ex_dst_addr);
  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign w_load_use = id_en & ex_en & ex_is_load & (ex_dst_addr != '0) & (w_rs1_hit | w_rs2_hit);

  // Ack on the final wait cycle wins over the watchdog; a trap aborts instead.
  assign w_tmo_hit = (state_q == c_MEM_WAIT) & ~w_mem_ack & ~trap_req & (tmo_cnt_q == c_TMO_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic for the memory-wait / trap-flush sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: begin
        if (w_mem_stall && !trap_req) state_d = c_MEM_WAIT;
      end
      c_MEM_WAIT: begin
        if (trap_req || w_mem_ack)        state_d = c_IDLE;
        else if (tmo_cnt_q == c_TMO_LAST) state_d = c_TRAP_FLUSH;
      end
      c_TRAP_FLUSH: state_d = c_IDLE;
      default:      state_d = c_IDLE;
    endcase
  end

  // Prioritised stall/flush decode: trap, memory wait, load-use, branch.
  always_comb begin
    w_mem_req  = w_mem_active & ~trap_req;
    w_pc_stall = 1'b0;
    w_if_stall = 1'b0;
    w_ex_stall = 1'b0;
    w_if_flush = 1'b0;
    w_ex_flush = 1'b0;
    if (trap_req || state_q == c_TRAP_FLUSH) begin
      w_if_flush = 1'b1;
      w_ex_flush = 1'b1;
    end else if (w_mem_stall) begin
      w_pc_stall = 1'b1;
      w_if_stall = 1'b1;
      w_ex_stall = 1'b1;
    end else if (w_load_use) begin
      w_pc_stall = 1'b1;
      w_if_stall = 1'b1;
      w_ex_flush = 1'b1;
    end else if (br_taken) begin
      w_if_flush = 1'b1;
    end
  end

  // Watchdog counter: held at zero outside MEM_WAIT so every entry starts from 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          tmo_cnt_q <= '0;
    else if (state_q != c_MEM_WAIT)                      tmo_cnt_q <= '0;
    else if (!w_mem_ack && tmo_cnt_q != c_TMO_LAST)      tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  // Timeout pulse lines up with the first TRAP_FLUSH cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_err_q <= 1'b0;
    else        timeout_err_q <= w_tmo_hit;
  end

  // Saturating count of PC-stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              stall_cnt_q <= '0;
    else if (w_pc_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  // Combinational controls are forced low while reset is held, whatever the inputs.
  assign mem_req     = reset & w_mem_req;
  assign pc_stall    = reset & w_pc_stall;
  assign if_stall    = reset & w_if_stall;
  assign ex_stall    = reset & w_ex_stall;
  assign if_flush    = reset & w_if_flush;
  assign ex_flush    = reset & w_ex_flush;
  assign timeout_err = timeout_err_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire
